// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - two-requester round-robin serial adder/subtractor, one nibble per cycle
// A single 4-bit carry look-ahead adder is time-shared across nibbles, LSB nibble first.

module cla_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_co
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

  assign o_s  = w_p ^ w_c[3:0];
  assign o_co = w_c[4];
endmodule

module serial_add_sched #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             SUB0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             SUB1,
  output logic [1:0]       GNT,
  output logic             BUSY,
  output logic [WIDTH-1:0] RESULT,
  output logic             CO,
  output logic             OVF,
  output logic [1:0]       DONE
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB + 1);
  localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

  typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_last;

  logic             w_pick;
  logic [CW+1:0]    w_sh;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum;
  logic             w_co;
  logic [WIDTH-1:0] w_final;
  logic             w_b_msb;
  logic             w_ovf;

  // Round-robin: on contention, serve whoever was not served last.
  assign w_pick = (REQ0 && REQ1) ? ~r_last : REQ1;

  assign w_sh    = {r_cnt, 2'b00};
  assign w_a_sh  = r_a >> w_sh;
  assign w_b_sh  = r_b >> w_sh;
  assign w_a_nib = w_a_sh[3:0];
  assign w_b_nib = w_b_sh[3:0] ^ {4{r_sub}};

  cla_adder u_cla (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_c  (r_carry),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  assign w_final = (r_sum & ~(NIB_MASK << w_sh)) | (WIDTH'(w_sum) << w_sh);
  assign w_b_msb = r_b[WIDTH-1] ^ r_sub;
  assign w_ovf   = ~(r_a[WIDTH-1] ^ w_b_msb) & (w_final[WIDTH-1] ^ r_a[WIDTH-1]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_last  <= 1'b1;
      GNT     <= 2'b00;
      BUSY    <= 1'b0;
      RESULT  <= '0;
      CO      <= 1'b0;
      OVF     <= 1'b0;
      DONE    <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            r_a     <= w_pick ? A1 : A0;
            r_b     <= w_pick ? B1 : B0;
            r_sub   <= w_pick ? SUB1 : SUB0;
            r_carry <= w_pick ? SUB1 : SUB0;
            r_cnt   <= '0;
            r_last  <= w_pick;
            GNT     <= w_pick ? 2'b10 : 2'b01;
            BUSY    <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_sum   <= w_final;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(NIB - 1)) begin
            RESULT  <= w_final;
            CO      <= w_co;
            OVF     <= w_ovf;
            DONE    <= GNT;
            r_state <= FIN;
          end
        end
        FIN: begin
          DONE    <= 2'b00;
          GNT     <= 2'b00;
          BUSY    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - directed and randomized checks of serial_add_sched against an arithmetic model

module tb_serial_add_sched;
  logic        CLK;
  logic        RST;
  logic        REQ0, REQ1, SUB0, SUB1;
  logic [15:0] A0, B0, A1, B1;
  logic [1:0]  GNT, DONE;
  logic        BUSY, CO, OVF;
  logic [15:0] RESULT;

  int tests = 0;
  int fails = 0;

  logic        m_last;
  logic [15:0] m_result;
  bit          m_chain;
  time         t_done;

  serial_add_sched #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .A0(A0), .B0(B0), .SUB0(SUB0),
    .REQ1(REQ1), .A1(A1), .B1(B1), .SUB1(SUB1),
    .GNT(GNT), .BUSY(BUSY), .RESULT(RESULT), .CO(CO), .OVF(OVF), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after FIN.
  task automatic op(input logic r0, input logic r1,
                    input logic [15:0] a0, input logic [15:0] b0, input logic s0,
                    input logic [15:0] a1, input logic [15:0] b1, input logic s1,
                    input bit keep, input bit scramble, input string tag);
    logic        g;
    logic [15:0] ea, eb, er;
    logic        es, eco, eovf;
    logic [16:0] full;
    logic [1:0]  oh;
    int          cyc;
    REQ0 = r0; A0 = a0; B0 = b0; SUB0 = s0;
    REQ1 = r1; A1 = a1; B1 = b1; SUB1 = s1;
    g = (r0 && r1) ? ~m_last : r1;
    m_last = g;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    es = g ? s1 : s0;
    full = es ? ({1'b0, ea} - {1'b0, eb}) : ({1'b0, ea} + {1'b0, eb});
    er   = full[15:0];
    eco  = es ? (ea >= eb) : full[16];
    eovf = es ? ((ea[15] != eb[15]) && (er[15] != ea[15]))
              : ((ea[15] == eb[15]) && (er[15] != ea[15]));
    oh = g ? 2'b10 : 2'b01;
    @(posedge CLK);
    @(negedge CLK);
    cyc = 1;
    chk({tag, ".gnt"}, GNT, oh);
    while (DONE == 2'b00 && cyc < 20) begin
      chk({tag, ".busy"}, BUSY, 1'b1);
      chk({tag, ".gnt_hold"}, GNT, oh);
      chk({tag, ".no_partial"}, RESULT, m_result);
      if (scramble) begin
        REQ0 = 1'b0; REQ1 = 1'b0;
        A0 = 16'($urandom); B0 = 16'($urandom); SUB0 = ~SUB0;
        A1 = 16'($urandom); B1 = 16'($urandom); SUB1 = ~SUB1;
      end
      @(negedge CLK);
      cyc++;
    end
    chk({tag, ".latency"}, cyc, 5);
    chk({tag, ".done"}, DONE, oh);
    chk({tag, ".fin_busy"}, BUSY, 1'b1);
    chk({tag, ".result"}, RESULT, er);
    chk({tag, ".co"}, CO, eco);
    chk({tag, ".ovf"}, OVF, eovf);
    if (m_chain) chk({tag, ".spacing"}, 32'($time - t_done), 60);
    t_done = $time;
    m_chain = keep;
    m_result = er;
    if (!keep) begin REQ0 = 1'b0; REQ1 = 1'b0; end
    @(negedge CLK);
    chk({tag, ".idle_busy"}, BUSY, 1'b0);
    chk({tag, ".idle_gnt"}, GNT, 2'b00);
    chk({tag, ".idle_done"}, DONE, 2'b00);
    chk({tag, ".hold"}, RESULT, er);
  endtask

  initial begin
    RST = 1'b1;
    REQ0 = 0; REQ1 = 0; SUB0 = 0; SUB1 = 0;
    A0 = 0; B0 = 0; A1 = 0; B1 = 0;
    m_last = 1'b1; m_result = '0; m_chain = 0; t_done = 0;
    #1;
    chk("rst.gnt", GNT, 2'b00);
    chk("rst.busy", BUSY, 1'b0);
    chk("rst.done", DONE, 2'b00);
    chk("rst.result", RESULT, 16'h0);
    chk("rst.co", CO, 1'b0);
    chk("rst.ovf", OVF, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    op(1, 0, 16'h1234, 16'h0FCD, 0, 0, 0, 0, 0, 0, "basic");
    op(1, 0, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0, 0, "carry");
    op(0, 1, 0, 0, 0, 16'h7FFF, 16'h0001, 0, 0, 0, "ovf_add");
    op(1, 0, 16'h0005, 16'h0007, 1, 0, 0, 0, 0, 0, "sub_borrow");
    op(0, 1, 0, 0, 0, 16'h8000, 16'h0001, 1, 0, 0, "sub_ovf");

    // Contention: both held for three back-to-back operations.
    op(1, 1, 16'h1111, 16'h2222, 0, 16'h3333, 16'h0444, 1, 1, 0, "rr0");
    op(1, 1, 16'h1111, 16'h2222, 0, 16'h3333, 16'h0444, 1, 1, 0, "rr1");
    op(1, 1, 16'h1111, 16'h2222, 0, 16'h3333, 16'h0444, 1, 0, 0, "rr2");

    // Requester 1 drops REQ and changes operands mid-operation.
    op(0, 1, 16'h0, 16'h0, 0, 16'hABCD, 16'h1357, 0, 0, 1, "latched");

    // Reset during ADD cycle 2.
    REQ0 = 1; A0 = 16'h4321; B0 = 16'h1111; SUB0 = 0;
    @(posedge CLK);
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst.gnt", GNT, 2'b00);
    chk("arst.busy", BUSY, 1'b0);
    chk("arst.done", DONE, 2'b00);
    chk("arst.result", RESULT, 16'h0);
    chk("arst.co", CO, 1'b0);
    chk("arst.ovf", OVF, 1'b0);
    REQ0 = 0;
    @(negedge CLK);
    RST = 1'b0;
    m_last = 1'b1; m_result = '0; m_chain = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("arst.no_done", DONE, 2'b00);
    end
    op(1, 1, 16'h0102, 16'h0304, 0, 16'h0506, 16'h0708, 0, 0, 0, "arst.first");

    for (int i = 0; i < 20; i++) begin
      int rq;
      rq = $urandom_range(1, 3);
      op(rq[0], rq[1], 16'($urandom), 16'($urandom), 1'($urandom),
         16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_add_sched.md
SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; the block SHALL support any multiple of 4 from 4 to 32; NIB = WIDTH/4.
REQ-002 Port: CLK  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 Port: RST  in  1  asynchronous, active-high reset.
REQ-004 Port: REQ0  in  1  requester 0 request.
REQ-005 Port: A0, B0  in  WIDTH each  requester 0 operands.
REQ-006 Port: SUB0  in  1  requester 0 op: 0 = A+B, 1 = A-B.
REQ-007 Port: REQ1, A1, B1, SUB1  in  1/WIDTH/WIDTH/1  requester 1, same meanings as requester 0.
REQ-008 Port: GNT  out  2  one-hot grant, bit i = requester i; held for the whole operation.
REQ-009 Port: BUSY  out  1  high while an operation is in progress.
REQ-010 Port: RESULT  out  WIDTH  sum/difference of the last completed operation.
REQ-011 Port: CO  out  1  final carry-out (subtract: 1 = no borrow).
REQ-012 Port: OVF  out  1  two's-complement overflow of the last completed operation.
REQ-013 Port: DONE  out  2  one-cycle completion pulse on the served requester's bit.

Function
REQ-014 The block SHALL instantiate exactly one cla_adder (4-bit carry look-ahead adder) and compute every result one nibble per cycle through it, LSB nibble first.
REQ-015 FSM states SHALL be IDLE, ADD, FIN; reset state is IDLE.
REQ-016 IDLE: on a rising edge with REQ0 or REQ1 high, the block SHALL grant one requester, latch its A, B and SUB, clear the nibble counter, and move to ADD; with no request it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: a single requester is granted; when both request, the requester not served last is granted; the last-served register resets to 1, so requester 0 wins the first contention.
REQ-018 ADD, cycle k (k = 0..NIB-1): adder inputs SHALL be nibble k of latched A, nibble k of latched B (inverted when SUB = 1), and the carry register.
REQ-019 In ADD, the carry register SHALL initialise to SUB at grant and update with the adder CO each cycle; nibble k of SUM SHALL be stored in an internal result register.
REQ-020 ADD SHALL last exactly NIB cycles, then move to FIN.
REQ-021 On entry to FIN, the block SHALL update RESULT, CO (final carry) and OVF = A[MSB] ~^ B'[MSB] & (SUM[MSB] ^ A[MSB]), where B' is the operand after inversion.
REQ-022 In FIN, DONE[i] SHALL be high for exactly that one cycle, then the FSM returns to IDLE.
REQ-023 Latency: DONE SHALL be high NIB+1 cycles after the grant edge; back-to-back throughput is NIB+2 cycles per operation.
REQ-024 GNT and BUSY SHALL be high from the grant edge through the FIN cycle inclusive, and low in IDLE.
REQ-025 RESULT, CO and OVF SHALL hold their values between FIN cycles and SHALL NOT show partial results.
REQ-026 While BUSY, REQ, operand and SUB changes SHALL be ignored; dropping REQ mid-operation SHALL NOT abort it.
REQ-027 Requesters SHALL hold REQ until they see their DONE bit; REQ still high in the IDLE cycle after FIN SHALL be treated as a new request.

Reset
REQ-028 RST high SHALL immediately force: state IDLE, GNT=00, BUSY=0, DONE=00, RESULT=0, CO=0, OVF=0, carry register and counter 0, last-served=1.
REQ-029 Reset during ADD or FIN SHALL abort the operation with no DONE pulse; the first rising edge after RST falls SHALL be able to grant.

Verification (WIDTH=16)
REQ-030 REQ0 only, A0=0x1234, B0=0x0FCD, SUB0=0 -> GNT=01; BUSY for 5 cycles; DONE=01 on the 5th cycle after the grant edge; RESULT=0x2201, CO=0, OVF=0.
REQ-031 Carry and overflow adds: 0xFFFF+0x0001 -> 0x0000, CO=1, OVF=0; 0x7FFF+0x0001 -> 0x8000, CO=0, OVF=1.
REQ-032 Subtracts: 0x0005-0x0007 -> 0xFFFE, CO=0, OVF=0; 0x8000-0x0001 -> 0x7FFF, CO=1, OVF=1.
REQ-033 REQ0 and REQ1 held high for three operations -> grants 01, 10, 01; DONE bits match; 6 cycles between successive DONEs.
REQ-034 RST pulsed during ADD cycle 2 -> all outputs zero asynchronously and no DONE; then both REQ high -> requester 0 granted first.
REQ-035 REQ1 granted, then REQ1 dropped and A1/B1 changed during ADD -> operation completes with the latched operands; DONE=10 and the result is correct.
